thruster_array: RTL
===================

Name: thruster_array

Overview:
- Multi-axis successor to the single-axis thruster integrator. CH independent channels, each integrating signed thrust into a saturating angular velocity, and velocity into an angle wrapped modulo ANG_MOD.
- Adds a damping mode that drives velocity to zero.
- Adds saturation and settled status flags, plus a per-channel mode register.
- Sits between the attitude command decoder and the orientation display/telemetry path.

Parameters:
- CH, 3, number of independent thruster channels (axes)
- W, 16, width of each thrust/velocity/angle word
- ANG_MOD, 360, angle modulus in units. Angle range is 0..ANG_MOD-1.
- VMAX, 300, velocity magnitude limit. Must satisfy 0 < VMAX < ANG_MOD and VMAX < 2^(W-1).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk
- up  in  CH  per-channel clockwise thrust command
- down  in  CH  per-channel counter-clockwise thrust command
- damp  in  CH  per-channel damping request
- thrust  in  CH*W  packed unsigned thrust magnitudes; channel i at [i*W +: W]
- velocity  out  CH*W  packed two's-complement velocities, registered
- angle  out  CH*W  packed unsigned angles, 0..ANG_MOD-1, registered
- mode  out  2*CH  per-channel mode, registered: 00 COAST, 01 ACCEL, 10 DECEL, 11 DAMP
- sat  out  CH  per-channel saturation flag, registered
- settled  out  CH  per-channel zero-velocity flag, registered

Behaviour:
- Reset (rst=0 at an edge): all velocity=0, angle=0, mode=COAST, sat=0, settled=1. Reset overrides every command.
- Channels are fully independent. A command on one channel never affects another.
- Mode select per channel, evaluated each edge, in priority order:
  - up XOR down: ACCEL if up, DECEL if down.
  - up AND down: COAST (conflicting commands cancel).
  - neither, damp=1: DAMP.
  - otherwise: COAST.
  - The mode register holds the mode applied at that edge.
- Raw next velocity, computed in at least W+2 signed bits:
  - ACCEL: v + thrust
  - DECEL: v - thrust
  - COAST: v
  - DAMP: v moves toward 0 by min(thrust, |v|). It never crosses zero; thrust=0 leaves v unchanged.
- Clamp the raw value to [-VMAX, +VMAX].
  - sat=1 for the cycle whose raw value lies strictly outside the range; otherwise sat=0.
  - A raw value exactly equal to ±VMAX does not set sat.
- Angle integrates the new (post-clamp) velocity on the same edge: a_next = (a + v_next) mod ANG_MOD, result always in 0..ANG_MOD-1.
  - Because |v_next| < ANG_MOD, one correction suffices: add ANG_MOD if the sum is negative, subtract ANG_MOD if the sum is ≥ ANG_MOD.
- settled = (v_next == 0), registered with velocity.
- Latency: one edge from command to velocity, angle, mode and flags. No combinational input-to-output paths.
- Reset asserted mid-motion zeroes the channel at that edge. Integration resumes from zero on the first edge with rst=1.

Test Plan:
(Defaults CH=3, W=16, ANG_MOD=360, VMAX=300.)
- Reset: rst=0 for one edge with up=3'b111, thrust=50 -> all velocity=0, angle=0, mode=00, sat=0, settled=3'b111.
- Ch0 accelerate and saturate: up[0]=1, thrust0=100, 4 edges.
  - velocity0 = 100, 200, 300, 300.
  - angle0 = 100, 300, 240, 180.
  - sat0 = 0, 0, 0, 1.
  - mode0 = 01.
- Ch0 reverse through zero: continue with down[0]=1, thrust0=100, 5 edges.
  - velocity0 = 200, 100, 0, -100, -200.
  - angle0 = 20, 120, 120, 20, 180 (negative wrap).
  - settled0 = 1 on the third edge only.
- Damp: continue with damp[0]=1, up/down=0, thrust0=150, 3 edges.
  - velocity0 = -50, 0, 0.
  - angle0 = 130, 130, 130.
  - mode0 = 11; settled0 = 0, 1, 1.
- Conflict and independence: up[1]=down[1]=1 with v1=50, while down[2]=1 with thrust2=30 and v2=0.
  - v1 stays 50, mode1=00, angle1 advances by 50.
  - v2 = -30, angle2 = 330, mode2=10.
  - ch0 is unchanged.
- Reset mid-operation: during ch0 ACCEL at v0=200, drive rst=0 for one edge.
  - All channels read 0/0/COAST/settled=1.
  - With up[0] still 1 and thrust0=100, next edge gives v0=100, angle0=100.

Source files
------------

// File: rtl/thruster_array.sv
// Multi-channel thruster integrator: saturating signed velocity per axis,
// angle wrapped modulo ANG_MOD, with accel/decel/damp/coast modes.
module thruster_array #(
    parameter int unsigned CH      = 3,
    parameter int unsigned W       = 16,
    parameter int unsigned ANG_MOD = 360,
    parameter int unsigned VMAX    = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     up,
    input  logic [CH-1:0]     down,
    input  logic [CH-1:0]     damp,
    input  logic [CH*W-1:0]   thrust,
    output logic [CH*W-1:0]   velocity,
    output logic [CH*W-1:0]   angle,
    output logic [2*CH-1:0]   mode,
    output logic [CH-1:0]     sat,
    output logic [CH-1:0]     settled
);

    localparam int unsigned XW = W + 2;
    localparam logic signed [XW-1:0] VMAX_X = XW'(VMAX);
    localparam logic signed [XW-1:0] ANG_X  = XW'(ANG_MOD);

    typedef enum logic [1:0] {
        COAST = 2'b00,
        ACCEL = 2'b01,
        DECEL = 2'b10,
        DAMP  = 2'b11
    } mode_t;

    mode_t                  mode_d  [CH];
    logic signed [XW-1:0]   v_cur   [CH];
    logic signed [XW-1:0]   t_ext   [CH];
    logic signed [XW-1:0]   raw     [CH];
    logic signed [XW-1:0]   a_sum   [CH];
    logic [W-1:0]           vel_d   [CH];
    logic [W-1:0]           ang_d   [CH];
    logic [CH-1:0]          sat_d;
    logic [CH-1:0]          settled_d;

    // Next mode, clamped velocity, wrapped angle and flags for every channel
    always_comb begin
        sat_d     = '0;
        settled_d = '0;
        for (int i = 0; i < CH; i++) begin
            mode_d[i] = COAST;
            v_cur[i]  = {{2{velocity[i*W+W-1]}}, velocity[i*W +: W]};
            t_ext[i]  = {2'b00, thrust[i*W +: W]};
            raw[i]    = v_cur[i];

            if (up[i] ^ down[i]) begin
                mode_d[i] = up[i] ? ACCEL : DECEL;
            end else if (!(up[i] & down[i]) && damp[i]) begin
                mode_d[i] = DAMP;
            end

            case (mode_d[i])
                ACCEL: raw[i] = v_cur[i] + t_ext[i];
                DECEL: raw[i] = v_cur[i] - t_ext[i];
                DAMP: begin
                    // Step toward zero, never past it
                    if (v_cur[i] < 0) begin
                        raw[i] = (t_ext[i] >= -v_cur[i]) ? '0 : v_cur[i] + t_ext[i];
                    end else begin
                        raw[i] = (t_ext[i] >= v_cur[i]) ? '0 : v_cur[i] - t_ext[i];
                    end
                end
                default: raw[i] = v_cur[i];
            endcase

            sat_d[i] = (raw[i] > VMAX_X) || (raw[i] < -VMAX_X);
            if (raw[i] > VMAX_X) begin
                vel_d[i] = W'(VMAX_X);
            end else if (raw[i] < -VMAX_X) begin
                vel_d[i] = W'(-VMAX_X);
            end else begin
                vel_d[i] = raw[i][W-1:0];
            end
            settled_d[i] = (vel_d[i] == '0);

            // |v| < ANG_MOD, so one correction brings the sum back into range
            a_sum[i] = {2'b00, angle[i*W +: W]} + {{2{vel_d[i][W-1]}}, vel_d[i]};
            if (a_sum[i] < 0) begin
                ang_d[i] = W'(a_sum[i] + ANG_X);
            end else if (a_sum[i] >= ANG_X) begin
                ang_d[i] = W'(a_sum[i] - ANG_X);
            end else begin
                ang_d[i] = a_sum[i][W-1:0];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            velocity <= '0;
            angle    <= '0;
            mode     <= '0;
            sat      <= '0;
            settled  <= '1;
        end else begin
            for (int i = 0; i < CH; i++) begin
                velocity[i*W +: W] <= vel_d[i];
                angle[i*W +: W]    <= ang_d[i];
                mode[2*i +: 2]     <= mode_d[i];
            end
            sat     <= sat_d;
            settled <= settled_d;
        end
    end

endmodule
